// File: rtl/compressor42_scheduler.sv
// compressor42_scheduler
// Drives one shared external 4:2 compressor to fold a stream of NUM_PP
// partial-product rows into a redundant (sum, carry) pair. Rows arrive in
// pairs: the first of each pair is parked in pend_q, the second is folded
// together with the accumulator through the compressor in the same cycle.
module compressor42_scheduler #(
    parameter int unsigned XLEN   = 49,
    parameter int unsigned NUM_PP = 8,
    localparam int unsigned CNT_W = $clog2(NUM_PP + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [XLEN-1:0]  PP_i,
    input  logic             PPValid_i,
    output logic             PPReady_o,
    input  logic             Flush_i,
    output logic [XLEN-1:0]  CmpA_o,
    output logic [XLEN-1:0]  CmpB_o,
    output logic [XLEN-1:0]  CmpC_o,
    output logic [XLEN-1:0]  CmpD_o,
    input  logic [XLEN-1:0]  CmpSum_i,
    input  logic [XLEN-1:0]  CmpCarry_i,
    output logic [XLEN-1:0]  Sum_o,
    output logic [XLEN-1:0]  Carry_o,
    output logic             Valid_o,
    input  logic             Ready_i,
    output logic [CNT_W-1:0] Count_o
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_PEND    = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   acc_sum_q, acc_sum_d;
    logic [XLEN-1:0]   acc_carry_q, acc_carry_d;
    logic [XLEN-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  count_inc;
    logic              accept;

    // Handshake outputs are decoded purely from the state register
    always_comb begin
        PPReady_o = (state_q != S_DONE);
        Valid_o   = (state_q == S_DONE);
        Sum_o     = Valid_o ? acc_sum_q   : '0;
        Carry_o   = Valid_o ? acc_carry_q : '0;
        Count_o   = count_q;
    end

    // Compressor operands: only a PEND pass feeds real C/D rows
    always_comb begin
        CmpA_o = acc_sum_q;
        CmpB_o = acc_carry_q;
        CmpC_o = '0;
        CmpD_o = '0;
        if (state_q == S_PEND) begin
            CmpC_o = pend_q;
            CmpD_o = PP_i;
        end
    end

    // Next-state and register-update logic; flush overrides everything
    always_comb begin
        state_d     = state_q;
        acc_sum_d   = acc_sum_q;
        acc_carry_d = acc_carry_q;
        pend_d      = pend_q;
        count_d     = count_q;
        accept      = PPValid_i & PPReady_o;
        count_inc   = count_q + CNT_W'(1);

        if (Flush_i) begin
            state_d     = S_COLLECT;
            acc_sum_d   = '0;
            acc_carry_d = '0;
            pend_d      = '0;
            count_d     = '0;
        end else begin
            unique case (state_q)
                S_COLLECT: begin
                    if (accept) begin
                        pend_d  = PP_i;
                        count_d = count_inc;
                        state_d = S_PEND;
                    end
                end
                S_PEND: begin
                    if (accept) begin
                        acc_sum_d   = CmpSum_i;
                        acc_carry_d = CmpCarry_i;
                        count_d     = count_inc;
                        state_d     = (count_inc == CNT_W'(NUM_PP)) ? S_DONE : S_COLLECT;
                    end
                end
                S_DONE: begin
                    if (Ready_i) begin
                        state_d     = S_COLLECT;
                        acc_sum_d   = '0;
                        acc_carry_d = '0;
                        pend_d      = '0;
                        count_d     = '0;
                    end
                end
                default: begin
                    state_d = S_COLLECT;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_COLLECT;
            acc_sum_q   <= '0;
            acc_carry_q <= '0;
            pend_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            acc_sum_q   <= acc_sum_d;
            acc_carry_q <= acc_carry_d;
            pend_q      <= pend_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_compressor42_scheduler.sv
// Testbench for compressor42_scheduler (XLEN=49, NUM_PP=4) with a
// behavioural 4:2 compressor closing the loop on the Cmp* ports.
module tb_compressor42_scheduler;

    localparam int unsigned XLEN   = 49;
    localparam int unsigned NUM_PP = 4;
    localparam int unsigned CNT_W  = 3;

    logic             clk_i;
    logic             rst_ni;
    logic [XLEN-1:0]  PP_i;
    logic             PPValid_i;
    logic             PPReady_o;
    logic             Flush_i;
    logic [XLEN-1:0]  CmpA_o, CmpB_o, CmpC_o, CmpD_o;
    logic [XLEN-1:0]  CmpSum_i, CmpCarry_i;
    logic [XLEN-1:0]  Sum_o, Carry_o;
    logic             Valid_o;
    logic             Ready_i;
    logic [CNT_W-1:0] Count_o;

    compressor42_scheduler #(
        .XLEN   (XLEN),
        .NUM_PP (NUM_PP)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .PP_i       (PP_i),
        .PPValid_i  (PPValid_i),
        .PPReady_o  (PPReady_o),
        .Flush_i    (Flush_i),
        .CmpA_o     (CmpA_o),
        .CmpB_o     (CmpB_o),
        .CmpC_o     (CmpC_o),
        .CmpD_o     (CmpD_o),
        .CmpSum_i   (CmpSum_i),
        .CmpCarry_i (CmpCarry_i),
        .Sum_o      (Sum_o),
        .Carry_o    (Carry_o),
        .Valid_o    (Valid_o),
        .Ready_i    (Ready_i),
        .Count_o    (Count_o)
    );

    // Two-level carry-save 4:2 compressor
    logic [XLEN-1:0] s1, c1;
    always_comb begin
        s1         = CmpA_o ^ CmpB_o ^ CmpC_o;
        c1         = ((CmpA_o & CmpB_o) | (CmpA_o & CmpC_o) | (CmpB_o & CmpC_o)) << 1;
        CmpSum_i   = s1 ^ c1 ^ CmpD_o;
        CmpCarry_i = ((s1 & c1) | (s1 & CmpD_o) | (c1 & CmpD_o)) << 1;
    end

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Reference model: the rows accepted in the current operation
    logic [XLEN-1:0] m_rows[$];
    logic            m_done;

    typedef struct {
        logic [3:0][XLEN-1:0] rows;
        logic [3:0][2:0]      gaps;
        int unsigned          hold;
        logic [XLEN-1:0]      exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] model_sum();
        logic [XLEN-1:0] s = '0;
        foreach (m_rows[i]) s = s + m_rows[i];
        return s;
    endfunction

    task automatic model_clear();
        m_rows.delete();
        m_done = 1'b0;
    endtask

    // Apply one cycle of inputs: check current outputs against the model,
    // let the clock edge happen, advance the model, return at the negedge.
    task automatic step(input logic v, input logic [XLEN-1:0] d, input logic rdy, input logic fl);
        logic [XLEN-1:0] got;
        PPValid_i = v;
        PP_i      = d;
        Ready_i   = rdy;
        Flush_i   = fl;
        #1;
        got = Sum_o + Carry_o;
        chk("valid", 64'(Valid_o), 64'(m_done));
        chk("ppready", 64'(PPReady_o), 64'(!m_done));
        chk("count", 64'(Count_o), 64'(m_rows.size()));
        if (m_done) chk("result", 64'(got), 64'(model_sum()));
        if (!m_done && (m_rows.size() % 2 == 1)) begin
            chk("opC_pend", 64'(CmpC_o), 64'(m_rows[$]));
            chk("opD_pend", 64'(CmpD_o), 64'(d));
        end else begin
            chk("opCD_idle", 64'({CmpC_o | CmpD_o}), 64'(0));
        end
        @(posedge clk_i);
        if (fl) begin
            model_clear();
        end else if (m_done) begin
            if (rdy) model_clear();
        end else if (v) begin
            m_rows.push_back(d);
            if (m_rows.size() == NUM_PP) m_done = 1'b1;
        end
        @(negedge clk_i);
    endtask

    task automatic run_op(input vec_t vc, input string tag);
        logic [XLEN-1:0] cap_s, cap_c, got;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < int'(vc.gaps[i]); g++) begin
                step(1'b0, '0, 1'b0, 1'b0);
                chk({tag, "_gap_count"}, 64'(Count_o), 64'(i));
            end
            step(1'b1, vc.rows[i], 1'b0, 1'b0);
            chk({tag, "_count_step"}, 64'(Count_o), 64'(i + 1));
        end
        // One cycle after the last accepted row
        #1;
        got = Sum_o + Carry_o;
        chk({tag, "_latency_valid"}, 64'(Valid_o), 64'(1));
        chk({tag, "_sum"}, 64'(got), 64'(vc.exp));
        chk({tag, "_count_done"}, 64'(Count_o), 64'(NUM_PP));
        cap_s = Sum_o;
        cap_c = Carry_o;
        for (int h = 0; h < int'(vc.hold); h++) begin
            step(1'b1, XLEN'(64'hDEAD_BEEF + h), 1'b0, 1'b0);
            chk({tag, "_hold_sum"}, 64'(Sum_o), 64'(cap_s));
            chk({tag, "_hold_carry"}, 64'(Carry_o), 64'(cap_c));
            chk({tag, "_hold_ready"}, 64'(PPReady_o), 64'(0));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk({tag, "_post_valid"}, 64'(Valid_o), 64'(0));
        chk({tag, "_post_count"}, 64'(Count_o), 64'(0));
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk({tag, "_rst_valid"}, 64'(Valid_o), 64'(0));
        chk({tag, "_rst_ready"}, 64'(PPReady_o), 64'(1));
        chk({tag, "_rst_count"}, 64'(Count_o), 64'(0));
        chk({tag, "_rst_sumcarry"}, 64'({Sum_o | Carry_o}), 64'(0));
        chk({tag, "_rst_acc"}, 64'({CmpA_o | CmpB_o}), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_clear();
    endtask

    initial begin
        vecs[0].rows = {49'd4, 49'd3, 49'd2, 49'd1};
        vecs[0].gaps = '0;  vecs[0].hold = 0; vecs[0].exp = 49'd10;
        vecs[1].rows = {4{49'h1_FFFF_FFFF_FFFF}};
        vecs[1].gaps = '0;  vecs[1].hold = 0; vecs[1].exp = 49'h1_FFFF_FFFF_FFFC;
        vecs[2].rows = {49'd4, 49'd3, 49'd2, 49'd1};
        vecs[2].gaps = {3'd2, 3'd2, 3'd2, 3'd0}; vecs[2].hold = 0; vecs[2].exp = 49'd10;
        vecs[3].rows = {4{49'd5}};
        vecs[3].gaps = '0;  vecs[3].hold = 5; vecs[3].exp = 49'd20;
        vecs[4].rows = {49'd1, 49'd0, 49'd0, 49'd7};
        vecs[4].gaps = '0;  vecs[4].hold = 0; vecs[4].exp = 49'd8;

        rst_ni    = 1'b0;
        PP_i      = '0;
        PPValid_i = 1'b0;
        Ready_i   = 1'b0;
        Flush_i   = 1'b0;
        model_clear();
        #1;
        chk("reset_valid", 64'(Valid_o), 64'(0));
        chk("reset_ready", 64'(PPReady_o), 64'(1));
        chk("reset_count", 64'(Count_o), 64'(0));
        chk("reset_sumcarry", 64'({Sum_o | Carry_o}), 64'(0));
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Flush after three rows, with a row offered in the flush cycle
        step(1'b1, 49'd1, 1'b0, 1'b0);
        step(1'b1, 49'd2, 1'b0, 1'b0);
        step(1'b1, 49'd3, 1'b0, 1'b0);
        step(1'b1, 49'd99, 1'b0, 1'b1);
        chk("flush_count", 64'(Count_o), 64'(0));
        chk("flush_ready", 64'(PPReady_o), 64'(1));
        run_op(vecs[3], "after_flush");

        // Flush in DONE beats a same-cycle Ready_i
        for (int i = 0; i < 4; i++) step(1'b1, XLEN'(i + 1), 1'b0, 1'b0);
        chk("done_before_flush", 64'(Valid_o), 64'(1));
        step(1'b0, '0, 1'b1, 1'b1);
        chk("flush_done_valid", 64'(Valid_o), 64'(0));
        chk("flush_done_count", 64'(Count_o), 64'(0));

        // Asynchronous reset in PEND, then in DONE
        step(1'b1, 49'd9, 1'b0, 1'b0);
        reset_pulse("pend");
        run_op(vecs[4], "after_rst_pend");
        for (int i = 0; i < 4; i++) step(1'b1, 49'd3, 1'b0, 1'b0);
        reset_pulse("done");
        run_op(vecs[4], "after_rst_done");

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 3) != 0,
                 {17'($urandom), $urandom},
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
